alu_rs_sched: RTL and testbench

- Reservation station and issue scheduler for the integer ALU in the out-of-order core.
- Accepts decoded instructions from dispatch and holds them until both source operands are available. Operands arrive either at dispatch or by snooping the ALU/LSB result buses (CDB).
- Issues at most one ready entry per cycle to the ALU.
- Flushes on rollback from the ROB.

---
 rtl/alu_rs_sched.sv | 276 +++++++++++++++++++++++++++
 tb/tb_alu_rs_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_sched.sv
// alu_rs_sched: reservation station and single-issue scheduler for the integer ALU.
// Holds dispatched instructions until both source operands are known,
// snoops the ALU and LSB result buses for wakeup, and issues one ready
// entry per cycle. Optional macro RS_AGE_ISSUE_EN switches issue selection
// from lowest-index to oldest-first (saturating per-entry age counters).
module alu_rs_sched #(
  parameter int RS_SIZE   = 8,
  parameter int RS_IDX_W  = 3,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 in_valid,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic                 in_funct7,
  input  logic                 in_q1_valid,
  input  logic [ROB_POS_W-1:0] in_q1,
  input  logic [31:0]          in_v1,
  input  logic                 in_q2_valid,
  input  logic [ROB_POS_W-1:0] in_q2,
  input  logic [31:0]          in_v2,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_pc,
  input  logic [ROB_POS_W-1:0] in_rob_pos,
  output logic                 full,
  input  logic                 alu_cdb_valid,
  input  logic [ROB_POS_W-1:0] alu_cdb_rob_pos,
  input  logic [31:0]          alu_cdb_val,
  input  logic                 lsb_cdb_valid,
  input  logic [ROB_POS_W-1:0] lsb_cdb_rob_pos,
  input  logic [31:0]          lsb_cdb_val,
  output logic                 alu_en,
  output logic [6:0]           alu_opcode,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7,
  output logic [31:0]          alu_val1,
  output logic [31:0]          alu_val2,
  output logic [31:0]          alu_imm,
  output logic [31:0]          alu_pc,
  output logic [ROB_POS_W-1:0] alu_rob_pos
);

  // Entry storage
  logic [RS_SIZE-1:0]   busy_reg, busy_next;
  logic [RS_SIZE-1:0]   q1_valid_reg, q1_valid_next;
  logic [RS_SIZE-1:0]   q2_valid_reg, q2_valid_next;
  logic [ROB_POS_W-1:0] q1_reg [RS_SIZE];
  logic [ROB_POS_W-1:0] q1_next [RS_SIZE];
  logic [ROB_POS_W-1:0] q2_reg [RS_SIZE];
  logic [ROB_POS_W-1:0] q2_next [RS_SIZE];
  logic [31:0]          v1_reg [RS_SIZE];
  logic [31:0]          v1_next [RS_SIZE];
  logic [31:0]          v2_reg [RS_SIZE];
  logic [31:0]          v2_next [RS_SIZE];
  logic [6:0]           opcode_reg [RS_SIZE];
  logic [6:0]           opcode_next [RS_SIZE];
  logic [2:0]           funct3_reg [RS_SIZE];
  logic [2:0]           funct3_next [RS_SIZE];
  logic [RS_SIZE-1:0]   funct7_reg, funct7_next;
  logic [31:0]          imm_reg [RS_SIZE];
  logic [31:0]          imm_next [RS_SIZE];
  logic [31:0]          pc_reg [RS_SIZE];
  logic [31:0]          pc_next [RS_SIZE];
  logic [ROB_POS_W-1:0] rob_pos_reg [RS_SIZE];
  logic [ROB_POS_W-1:0] rob_pos_next [RS_SIZE];

  logic [RS_SIZE-1:0]   ready;
  logic                 free_found;
  logic [RS_IDX_W-1:0]  free_idx;
  logic                 do_dispatch;
  logic                 issue_valid;
  logic [RS_IDX_W-1:0]  issue_idx;
  logic                 d_q1_valid, d_q2_valid;
  logic [31:0]          d_v1, d_v2;

  assign ready       = busy_reg & ~q1_valid_reg & ~q2_valid_reg;
  assign full        = &busy_reg;
  assign do_dispatch = in_valid && !full;

  // Lowest-index free slot for dispatch
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy_reg[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = i[RS_IDX_W-1:0];
      end
    end
  end

  // Dispatch-time forwarding from the CDBs; the ALU bus has priority
  always_comb begin
    d_q1_valid = in_q1_valid;
    d_v1       = in_v1;
    d_q2_valid = in_q2_valid;
    d_v2       = in_v2;
    if (in_q1_valid) begin
      if (alu_cdb_valid && alu_cdb_rob_pos == in_q1) begin
        d_q1_valid = 1'b0;
        d_v1       = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_rob_pos == in_q1) begin
        d_q1_valid = 1'b0;
        d_v1       = lsb_cdb_val;
      end
    end
    if (in_q2_valid) begin
      if (alu_cdb_valid && alu_cdb_rob_pos == in_q2) begin
        d_q2_valid = 1'b0;
        d_v2       = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_rob_pos == in_q2) begin
        d_q2_valid = 1'b0;
        d_v2       = lsb_cdb_val;
      end
    end
  end

`ifdef RS_AGE_ISSUE_EN
  logic [RS_IDX_W:0] age_reg [RS_SIZE];
  logic [RS_IDX_W:0] age_next [RS_SIZE];
  logic [RS_IDX_W:0] best_age;

  // Oldest ready entry wins; strict compare keeps the lower index on ties
  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    best_age    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (!issue_valid || age_reg[i] > best_age)) begin
        issue_valid = 1'b1;
        issue_idx   = i[RS_IDX_W-1:0];
        best_age    = age_reg[i];
      end
    end
  end

  // New entry starts at age 0; every other busy entry ages on a dispatch
  always_comb begin
    age_next = age_reg;
    if (do_dispatch) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (i[RS_IDX_W-1:0] == free_idx)
          age_next[i] = '0;
        else if (busy_reg[i] && age_reg[i] != '1)
          age_next[i] = age_reg[i] + {{RS_IDX_W{1'b0}}, 1'b1};
      end
    end
  end

  // Age counters advance only while the core is running
  always_ff @(posedge clk) begin
    if (!rst && rdy)
      age_reg <= age_next;
  end
`else
  // Lowest-index ready entry wins
  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && !issue_valid) begin
        issue_valid = 1'b1;
        issue_idx   = i[RS_IDX_W-1:0];
      end
    end
  end
`endif

  // Per-entry next state: wakeup, issue release, dispatch write, rollback
  always_comb begin
    busy_next     = busy_reg;
    q1_valid_next = q1_valid_reg;
    q2_valid_next = q2_valid_reg;
    q1_next       = q1_reg;
    q2_next       = q2_reg;
    v1_next       = v1_reg;
    v2_next       = v2_reg;
    opcode_next   = opcode_reg;
    funct3_next   = funct3_reg;
    funct7_next   = funct7_reg;
    imm_next      = imm_reg;
    pc_next       = pc_reg;
    rob_pos_next  = rob_pos_reg;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_reg[i] && q1_valid_reg[i]) begin
        if (alu_cdb_valid && alu_cdb_rob_pos == q1_reg[i]) begin
          q1_valid_next[i] = 1'b0;
          v1_next[i]       = alu_cdb_val;
        end else if (lsb_cdb_valid && lsb_cdb_rob_pos == q1_reg[i]) begin
          q1_valid_next[i] = 1'b0;
          v1_next[i]       = lsb_cdb_val;
        end
      end
      if (busy_reg[i] && q2_valid_reg[i]) begin
        if (alu_cdb_valid && alu_cdb_rob_pos == q2_reg[i]) begin
          q2_valid_next[i] = 1'b0;
          v2_next[i]       = alu_cdb_val;
        end else if (lsb_cdb_valid && lsb_cdb_rob_pos == q2_reg[i]) begin
          q2_valid_next[i] = 1'b0;
          v2_next[i]       = lsb_cdb_val;
        end
      end
      if (issue_valid && issue_idx == i[RS_IDX_W-1:0])
        busy_next[i] = 1'b0;
      if (do_dispatch && free_idx == i[RS_IDX_W-1:0]) begin
        busy_next[i]     = 1'b1;
        q1_valid_next[i] = d_q1_valid;
        q1_next[i]       = in_q1;
        v1_next[i]       = d_v1;
        q2_valid_next[i] = d_q2_valid;
        q2_next[i]       = in_q2;
        v2_next[i]       = d_v2;
        opcode_next[i]   = in_opcode;
        funct3_next[i]   = in_funct3;
        funct7_next[i]   = in_funct7;
        imm_next[i]      = in_imm;
        pc_next[i]       = in_pc;
        rob_pos_next[i]  = in_rob_pos;
      end
    end
    if (rollback)
      busy_next = '0;
  end

  // Entry state register; frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else if (rdy) begin
      busy_reg     <= busy_next;
      q1_valid_reg <= q1_valid_next;
      q2_valid_reg <= q2_valid_next;
      q1_reg       <= q1_next;
      q2_reg       <= q2_next;
      v1_reg       <= v1_next;
      v2_reg       <= v2_next;
      opcode_reg   <= opcode_next;
      funct3_reg   <= funct3_next;
      funct7_reg   <= funct7_next;
      imm_reg      <= imm_next;
      pc_reg       <= pc_next;
      rob_pos_reg  <= rob_pos_next;
    end
  end

  // Registered issue port; data holds when nothing issues
  always_ff @(posedge clk) begin
    if (rst || (rdy && rollback)) begin
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      alu_en <= issue_valid;
      if (issue_valid) begin
        alu_opcode  <= opcode_reg[issue_idx];
        alu_funct3  <= funct3_reg[issue_idx];
        alu_funct7  <= funct7_reg[issue_idx];
        alu_val1    <= v1_reg[issue_idx];
        alu_val2    <= v2_reg[issue_idx];
        alu_imm     <= imm_reg[issue_idx];
        alu_pc      <= pc_reg[issue_idx];
        alu_rob_pos <= rob_pos_reg[issue_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_sched.sv
// Bench for alu_rs_sched: directed vectors, a behavioural reservation-station
// model checked every cycle, and hand-computed literal expectations.
module tb_alu_rs_sched;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, in_valid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7;
  logic        in_q1_valid, in_q2_valid;
  logic [3:0]  in_q1, in_q2, in_rob_pos;
  logic [31:0] in_v1, in_v2, in_imm, in_pc;
  logic        full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_pos, lsb_cdb_rob_pos;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  alu_rs_sched #(.RS_SIZE(8), .RS_IDX_W(3), .ROB_POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_q1_valid(in_q1_valid), .in_q1(in_q1),
    .in_v1(in_v1), .in_q2_valid(in_q2_valid), .in_q2(in_q2), .in_v2(in_v2),
    .in_imm(in_imm), .in_pc(in_pc), .in_rob_pos(in_rob_pos), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_pos(alu_cdb_rob_pos),
    .alu_cdb_val(alu_cdb_val), .lsb_cdb_valid(lsb_cdb_valid),
    .lsb_cdb_rob_pos(lsb_cdb_rob_pos), .lsb_cdb_val(lsb_cdb_val),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        busy;
    logic        q1v, q2v;
    logic [3:0]  q1, q2, rob;
    logic [31:0] v1, v2, imm, pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } ent_t;

  ent_t        m [8];
  int          m_free, m_sel;
  logic        e_en, e_f7;
  logic [6:0]  e_op;
  logic [2:0]  e_f3;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [3:0]  e_rob;

  function automatic bit cdb_hit(input logic [3:0] tag);
    return (alu_cdb_valid && alu_cdb_rob_pos == tag) || (lsb_cdb_valid && lsb_cdb_rob_pos == tag);
  endfunction

  function automatic logic [31:0] cdb_val(input logic [3:0] tag);
    if (alu_cdb_valid && alu_cdb_rob_pos == tag) return alu_cdb_val;
    return lsb_cdb_val;
  endfunction

  // Model advances on the same edge as the DUT, from the same inputs
  always @(posedge clk) begin
    if (rst || (rdy && rollback)) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      e_en = 0; e_op = 0; e_f3 = 0; e_f7 = 0;
      e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    end else if (rdy) begin
      m_free = -1;
      for (int i = 7; i >= 0; i--) if (!m[i].busy) m_free = i;
      m_sel = -1;
      for (int i = 0; i < 8; i++)
        if (m_sel < 0 && m[i].busy && !m[i].q1v && !m[i].q2v) m_sel = i;
      e_en = (m_sel >= 0);
      if (m_sel >= 0) begin
        e_op = m[m_sel].op; e_f3 = m[m_sel].f3; e_f7 = m[m_sel].f7;
        e_v1 = m[m_sel].v1; e_v2 = m[m_sel].v2; e_imm = m[m_sel].imm;
        e_pc = m[m_sel].pc; e_rob = m[m_sel].rob;
        m[m_sel].busy = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        if (m[i].busy && m[i].q1v && cdb_hit(m[i].q1)) begin
          m[i].v1 = cdb_val(m[i].q1); m[i].q1v = 1'b0;
        end
        if (m[i].busy && m[i].q2v && cdb_hit(m[i].q2)) begin
          m[i].v2 = cdb_val(m[i].q2); m[i].q2v = 1'b0;
        end
      end
      if (in_valid && m_free >= 0) begin
        m[m_free].busy = 1'b1;
        m[m_free].op = in_opcode; m[m_free].f3 = in_funct3; m[m_free].f7 = in_funct7;
        m[m_free].imm = in_imm; m[m_free].pc = in_pc; m[m_free].rob = in_rob_pos;
        m[m_free].q1 = in_q1; m[m_free].q2 = in_q2;
        m[m_free].q1v = in_q1_valid && !cdb_hit(in_q1);
        m[m_free].v1  = (in_q1_valid && cdb_hit(in_q1)) ? cdb_val(in_q1) : in_v1;
        m[m_free].q2v = in_q2_valid && !cdb_hit(in_q2);
        m[m_free].v2  = (in_q2_valid && cdb_hit(in_q2)) ? cdb_val(in_q2) : in_v2;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      logic mf;
      mf = 1'b1;
      for (int i = 0; i < 8; i++) if (!m[i].busy) mf = 1'b0;
      chk("full", full, mf);
      chk("alu_en", alu_en, e_en);
      chk("alu_data", {alu_opcode, alu_funct3, alu_funct7, alu_rob_pos}, {e_op, e_f3, e_f7, e_rob});
      chk("alu_val1", alu_val1, e_v1);
      chk("alu_val2", alu_val2, e_v2);
      chk("alu_imm", alu_imm, e_imm);
      chk("alu_pc", alu_pc, e_pc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input logic [6:0] op, input logic [2:0] f3,
                      input logic q1v, input logic [3:0] q1, input logic [31:0] v1,
                      input logic q2v, input logic [3:0] q2, input logic [31:0] v2,
                      input logic [31:0] imm, input logic [3:0] rob);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7 = f3[0];
    in_q1_valid = q1v; in_q1 = q1; in_v1 = v1;
    in_q2_valid = q2v; in_q2 = q2; in_v2 = v2;
    in_imm = imm; in_pc = 32'h1000 + 32'(rob) * 4; in_rob_pos = rob;
  endtask

  task automatic bcast(input logic av, input logic [3:0] at, input logic [31:0] aval,
                       input logic lv, input logic [3:0] lt, input logic [31:0] lval);
    alu_cdb_valid = av; alu_cdb_rob_pos = at; alu_cdb_val = aval;
    lsb_cdb_valid = lv; lsb_cdb_rob_pos = lt; lsb_cdb_val = lval;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
    in_opcode = 0; in_funct3 = 0; in_funct7 = 0;
    in_q1_valid = 0; in_q1 = 0; in_v1 = 0; in_q2_valid = 0; in_q2 = 0; in_v2 = 0;
    in_imm = 0; in_pc = 0; in_rob_pos = 0;
    bcast(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset, then idle
    tick(); tick();
    rst = 1'b0;
    cmp_on = 1'b1;
    chk("reset_full", full, 0);
    chk("reset_alu_en", alu_en, 0);
    chk("reset_val1", alu_val1, 0);
    repeat (10) tick();
    chk("idle_alu_en", alu_en, 0);

    // addi with ready operands: issues after the second edge
    disp(7'h13, 3'd0, 0, 0, 32'd5, 0, 0, 32'd0, 32'd7, 4'd3);
    tick();
    in_valid = 1'b0;
    chk("addi_not_yet", alu_en, 0);
    tick();
    chk("addi_en", alu_en, 1);
    chk("addi_val1", alu_val1, 32'd5);
    chk("addi_imm", alu_imm, 32'd7);
    chk("addi_rob", alu_rob_pos, 4'd3);
    tick();
    chk("addi_done", alu_en, 0);

    // add waiting on tag 2, woken by ALU CDB
    disp(7'h33, 3'd0, 1, 4'd2, 32'd0, 0, 0, 32'd10, 32'd0, 4'd4);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    bcast(1, 4'd2, 32'h20, 0, 0, 0);
    tick();
    bcast(0, 0, 0, 0, 0, 0);
    chk("wake_not_yet", alu_en, 0);
    tick();
    chk("wake_en", alu_en, 1);
    chk("wake_val1", alu_val1, 32'h20);
    chk("wake_val2", alu_val2, 32'd10);

    // Dispatch-time forward from LSB CDB
    disp(7'h33, 3'd7, 0, 0, 32'd1, 1, 4'd6, 32'd0, 32'd0, 4'd5);
    bcast(0, 0, 0, 1, 4'd6, 32'hDEAD);
    tick();
    in_valid = 1'b0;
    bcast(0, 0, 0, 0, 0, 0);
    tick();
    chk("fwd_en", alu_en, 1);
    chk("fwd_val2", alu_val2, 32'hDEAD);

    // Both CDBs carry the same tag at dispatch: ALU wins
    disp(7'h33, 3'd1, 1, 4'd7, 32'd0, 0, 0, 32'd3, 32'd0, 4'd6);
    bcast(1, 4'd7, 32'h111, 1, 4'd7, 32'h222);
    tick();
    in_valid = 1'b0;
    bcast(0, 0, 0, 0, 0, 0);
    tick();
    chk("prio_val1", alu_val1, 32'h111);

    // Fill all eight entries with pending operands (tags 8..15)
    for (int i = 0; i < 8; i++) begin
      disp(7'h33, 3'd0, 1, 4'(8 + i), 32'd0, 0, 0, 32'(i), 32'd0, 4'(i));
      tick();
    end
    in_valid = 1'b0;
    chk("fill_full", full, 1);
    disp(7'h13, 3'd0, 0, 0, 32'd9, 0, 0, 32'd0, 32'd0, 4'd15);
    tick();
    in_valid = 1'b0;
    chk("drop_en0", alu_en, 0);
    tick();
    chk("drop_en1", alu_en, 0);
    bcast(1, 4'd8, 32'h88, 0, 0, 0);
    tick();
    bcast(0, 0, 0, 0, 0, 0);
    chk("fill_still_full", full, 1);
    tick();
    chk("fill_issue_en", alu_en, 1);
    chk("fill_issue_rob", alu_rob_pos, 4'd0);
    chk("fill_issue_val1", alu_val1, 32'h88);
    chk("fill_not_full", full, 0);

    // rdy low freezes everything, including the issue port and wakeups
    rdy = 1'b0;
    bcast(1, 4'd9, 32'h99, 0, 0, 0);
    tick();
    chk("frz_en", alu_en, 1);
    chk("frz_rob", alu_rob_pos, 4'd0);
    bcast(0, 0, 0, 0, 0, 0);
    rdy = 1'b1;
    tick();
    chk("frz_no_wake", alu_en, 0);

    // Rollback clears the station
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    chk("rb0_full", full, 0);
    chk("rb0_en", alu_en, 0);
    for (int i = 0; i < 5; i++) begin
      disp(7'h33, 3'd2, 1, 4'(1 + i), 32'd0, 0, 0, 32'd1, 32'd0, 4'(1 + i));
      tick();
    end
    in_valid = 1'b0;
    bcast(1, 4'd1, 32'hA1, 1, 4'd2, 32'hA2);
    tick();
    bcast(0, 0, 0, 0, 0, 0);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    chk("rb_en", alu_en, 0);
    chk("rb_full", full, 0);
    chk("rb_val1", alu_val1, 0);
    bcast(1, 4'd3, 32'h3, 1, 4'd4, 32'h4);
    tick();
    bcast(1, 4'd5, 32'h5, 0, 0, 0);
    tick();
    bcast(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rb_no_issue", alu_en, 0);

    // Tag 0 wakes two entries at once: lower index issues first
    disp(7'h33, 3'd0, 1, 4'd0, 32'd0, 0, 0, 32'hA, 32'd0, 4'd10);
    tick();
    disp(7'h33, 3'd0, 1, 4'd0, 32'd0, 0, 0, 32'hB, 32'd0, 4'd11);
    tick();
    in_valid = 1'b0;
    bcast(0, 0, 0, 1, 4'd0, 32'h5);
    tick();
    bcast(0, 0, 0, 0, 0, 0);
    tick();
    chk("tag0_first_rob", alu_rob_pos, 4'd10);
    chk("tag0_first_val1", alu_val1, 32'h5);
    tick();
    chk("tag0_second_rob", alu_rob_pos, 4'd11);
    chk("tag0_second_en", alu_en, 1);
    tick();
    chk("tag0_done", alu_en, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
